alu_logic_arbiter: RTL and testbench

//  Shares one 16-bit bitwise logic unit (NOT/AND/OR/XOR) between two requesters.

---
 rtl/alu_logic_arbiter_pkg.sv | 27 ++
 rtl/logic_unit_16bit.sv | 34 +++
 rtl/alu_logic_arbiter.sv | 132 +++++++++++++
 tb/tb_alu_logic_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_logic_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// alu_logic_arbiter_pkg
// Shared definitions for the shared logic-unit arbiter: default widths,
// opcode encodings of the bitwise logic unit and the sequencing FSM states.
// No ports (package).
// -----------------------------------------------------------------------------
package alu_logic_arbiter_pkg;

    localparam int DATA_W = 16;
    localparam int OP_W   = 2;

    // Bitwise operation codes; all four encodings are legal.
    typedef enum logic [1:0] {
        OP_NOT = 2'b00,
        OP_AND = 2'b01,
        OP_OR  = 2'b10,
        OP_XOR = 2'b11
    } op_t;

    // accept -> execute -> respond sequencing
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_RESP = 2'b10
    } state_t;

endpackage

// File: rtl/logic_unit_16bit.sv
// -----------------------------------------------------------------------------
// logic_unit_16bit
// Purely combinational bitwise unit: Y = ~A, A&B, A|B or A^B by opcode.
// Ports:
//   i_op  [OPW-1:0]    opcode (see op_t)
//   i_a   [WIDTH-1:0]  operand A
//   i_b   [WIDTH-1:0]  operand B (unused for NOT)
//   o_y   [WIDTH-1:0]  result
// -----------------------------------------------------------------------------
module logic_unit_16bit
    import alu_logic_arbiter_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int OPW   = OP_W
) (
    input  logic [OPW-1:0]   i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_y
);

    // Opcode decode of the bitwise operation
    always_comb begin
        o_y = '0;
        case (i_op)
            OP_NOT:  o_y = ~i_a;
            OP_AND:  o_y = i_a & i_b;
            OP_OR:   o_y = i_a | i_b;
            OP_XOR:  o_y = i_a ^ i_b;
            default: o_y = '0;
        endcase
    end

endmodule

// File: rtl/alu_logic_arbiter.sv
// -----------------------------------------------------------------------------
// alu_logic_arbiter
// Shares one bitwise logic unit between two requesters. Round-robin grant in
// IDLE, operands captured on accept, one EXEC cycle, then the result is held
// in RESP until the consumer takes it. One operation in flight at a time.
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   reqN_valid/ready/op/a/b      request channel of requester N (N = 0, 1)
//   rsp_valid/ready              response handshake
//   rsp_id                       requester that issued the result
//   rsp_y, rsp_zero              result and (result == 0) flag
//   busy                         high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module alu_logic_arbiter
    import alu_logic_arbiter_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int OPW   = OP_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [OPW-1:0]   req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [OPW-1:0]   req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_y,
    output logic             rsp_zero,
    output logic             busy
);

    state_t           r_state;
    logic [OPW-1:0]   r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_id;
    logic             r_last_grant;

    logic             w_any_valid;
    logic             w_grant_id;
    logic             w_idle;
    logic [WIDTH-1:0] w_y;

    // Round-robin grant and combinational ready; ready is forced low while
    // reset is asserted so nothing can be accepted during reset.
    always_comb begin
        w_any_valid = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            w_grant_id = ~r_last_grant;
        end else if (req1_valid) begin
            w_grant_id = 1'b1;
        end else begin
            w_grant_id = 1'b0;
        end
        w_idle     = (r_state == S_IDLE) && !rst;
        req0_ready = w_idle && req0_valid && (w_grant_id == 1'b0);
        req1_ready = w_idle && req1_valid && (w_grant_id == 1'b1);
    end

    assign busy = (r_state != S_IDLE);

    logic_unit_16bit #(
        .WIDTH (WIDTH),
        .OPW   (OPW)
    ) u_logic_unit (
        .i_op (r_op),
        .i_a  (r_a),
        .i_b  (r_b),
        .o_y  (w_y)
    );

    // Sequencing FSM with operand capture and response registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_op         <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_id         <= 1'b0;
            // Pointer at 1 so requester 0 wins the first contention.
            r_last_grant <= 1'b1;
            rsp_valid    <= 1'b0;
            rsp_id       <= 1'b0;
            rsp_y        <= '0;
            rsp_zero     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_valid) begin
                        r_id    <= w_grant_id;
                        r_op    <= w_grant_id ? req1_op : req0_op;
                        r_a     <= w_grant_id ? req1_a  : req0_a;
                        r_b     <= w_grant_id ? req1_b  : req0_b;
                        r_state <= S_EXEC;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_EXEC: begin
                    rsp_y     <= w_y;
                    rsp_zero  <= (w_y == '0);
                    rsp_id    <= r_id;
                    rsp_valid <= 1'b1;
                    r_state   <= S_RESP;
                end
                S_RESP: begin
                    // Result stays frozen until the consumer accepts it.
                    if (rsp_ready) begin
                        rsp_valid    <= 1'b0;
                        r_last_grant <= rsp_id;
                        r_state      <= S_IDLE;
                    end else begin
                        r_state <= S_RESP;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_logic_arbiter.sv
module tb_alu_logic_arbiter;

    logic        clk;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [1:0]  req0_op, req1_op;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, busy;
    logic [15:0] rsp_y;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] both_cnt = 16'd0;

    alu_logic_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_y      (rsp_y),
        .rsp_zero   (rsp_zero),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Both readys high at once is never allowed; sampled mid-cycle.
    always begin
        @(posedge clk);
        #3;
        if (req0_ready && req1_ready) both_cnt = both_cnt + 16'd1;
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Single op from one requester, rsp_ready held high; called at negedge+1.
    task automatic run_op(input string tag, input logic id, input logic [1:0] op,
                          input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp_y, input logic exp_z);
        if (id) begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end
        rsp_ready = 1'b1;
        #1;
        chk1({tag, "_ready"}, id ? req1_ready : req0_ready, 1'b1);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        chk1({tag, "_exec_valid"}, rsp_valid, 1'b0);
        chk1({tag, "_exec_busy"}, busy, 1'b1);
        @(negedge clk); #1;
        chk1({tag, "_rsp_valid"}, rsp_valid, 1'b1);
        chk16({tag, "_rsp_y"}, rsp_y, exp_y);
        chk1({tag, "_rsp_id"}, rsp_id, id);
        chk1({tag, "_rsp_zero"}, rsp_zero, exp_z);
        @(negedge clk); #1;
        chk1({tag, "_done_valid"}, rsp_valid, 1'b0);
        chk1({tag, "_done_busy"}, busy, 1'b0);
    endtask

    int          acc_cyc[$];
    logic        acc_id[$];
    logic        rsp_ids[$];

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req0_op = 2'b00; req0_a = 16'h0000; req0_b = 16'h0000;
        req1_valid = 1'b0; req1_op = 2'b00; req1_a = 16'h0000; req1_b = 16'h0000;
        rsp_ready = 1'b0;

        // Reset state; a valid request must not be accepted during reset.
        @(negedge clk);
        req0_valid = 1'b1;
        #1;
        chk1("rst_ready0", req0_ready, 1'b0);
        chk1("rst_rsp_valid", rsp_valid, 1'b0);
        chk16("rst_rsp_y", rsp_y, 16'h0000);
        chk1("rst_rsp_id", rsp_id, 1'b0);
        chk1("rst_rsp_zero", rsp_zero, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        req0_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk); #1;

        // 1/2: single-requester operations
        run_op("t1_not", 1'b0, 2'b00, 16'hAAAA, 16'h0000, 16'h5555, 1'b0);
        run_op("t2_not", 1'b0, 2'b00, 16'hFFFF, 16'h0000, 16'h0000, 1'b1);
        run_op("t2_xor", 1'b1, 2'b11, 16'h1234, 16'h1234, 16'h0000, 1'b1);

        // 3: contention straight out of reset -> req0 first
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        req0_valid = 1'b1; req0_op = 2'b01; req0_a = 16'hAAAA; req0_b = 16'hFFFF;
        req1_valid = 1'b1; req1_op = 2'b10; req1_a = 16'h5555; req1_b = 16'hAAAA;
        rsp_ready = 1'b1;
        #1;
        chk1("t3_ready0", req0_ready, 1'b1);
        chk1("t3_ready1_blocked", req1_ready, 1'b0);
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        chk1("t3_exec_ready1", req1_ready, 1'b0);
        @(negedge clk); #1;
        chk1("t3_rsp0_valid", rsp_valid, 1'b1);
        chk16("t3_rsp0_y", rsp_y, 16'hAAAA);
        chk1("t3_rsp0_id", rsp_id, 1'b0);
        chk1("t3_resp_ready1", req1_ready, 1'b0);
        @(negedge clk); #1;
        chk1("t3_ready1", req1_ready, 1'b1);
        @(negedge clk);
        req1_valid = 1'b0;
        @(negedge clk); #1;
        chk1("t3_rsp1_valid", rsp_valid, 1'b1);
        chk16("t3_rsp1_y", rsp_y, 16'hFFFF);
        chk1("t3_rsp1_id", rsp_id, 1'b1);
        @(negedge clk); #1;

        // 4: both held valid -> alternation, one accept every 3 cycles
        req0_valid = 1'b1; req0_op = 2'b01; req0_a = 16'hF0F0; req0_b = 16'hFF00;
        req1_valid = 1'b1; req1_op = 2'b11; req1_a = 16'hFFFF; req1_b = 16'h0F0F;
        #1;
        for (int i = 0; i < 12; i++) begin
            if (req0_ready || req1_ready) begin
                acc_cyc.push_back(i);
                acc_id.push_back(req1_ready);
            end
            if (rsp_valid) begin
                rsp_ids.push_back(rsp_id);
                chk16("t4_rsp_y", rsp_y, rsp_id ? 16'hF0F0 : 16'hF000);
            end
            @(negedge clk); #1;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk16("t4_accept_count", 16'(acc_cyc.size()), 16'd4);
        chk16("t4_rsp_count", 16'(rsp_ids.size()), 16'd4);
        if (acc_cyc.size() == 4 && rsp_ids.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                chk16("t4_accept_cycle", 16'(acc_cyc[k]), 16'(3 * k));
                chk1("t4_accept_id", acc_id[k], k[0]);
                chk1("t4_rsp_id_seq", rsp_ids[k], k[0]);
            end
        end
        @(negedge clk); #1;

        // 5: backpressure in RESP for 10 cycles while req1 waits
        req0_valid = 1'b1; req0_op = 2'b10; req0_a = 16'h0000; req0_b = 16'h0000;
        rsp_ready = 1'b0;
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_op = 2'b00; req1_a = 16'h00FF; req1_b = 16'h0000;
        @(negedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            chk16("t5_hold_flags", {11'd0, rsp_valid, rsp_id, rsp_zero, req0_ready, req1_ready},
                  16'b0000_0000_0001_0100);
            chk16("t5_hold_y", rsp_y, 16'h0000);
            @(negedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(negedge clk); #1;
        chk1("t5_released_valid", rsp_valid, 1'b0);
        chk1("t5_idle_ready1", req1_ready, 1'b1);
        @(negedge clk);
        req1_valid = 1'b0;
        @(negedge clk); #1;
        chk1("t5_rsp1_valid", rsp_valid, 1'b1);
        chk16("t5_rsp1_y", rsp_y, 16'hFF00);
        chk1("t5_rsp1_id", rsp_id, 1'b1);
        @(negedge clk); #1;

        // 6: reset in EXEC clears outputs immediately and drops the op
        req0_valid = 1'b1; req0_op = 2'b01; req0_a = 16'hFFFF; req0_b = 16'h1234;
        @(negedge clk); #1;
        chk1("t6_exec_busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        chk16("t6_async_y", rsp_y, 16'h0000);
        chk1("t6_async_id", rsp_id, 1'b0);
        chk1("t6_async_busy", busy, 1'b0);
        chk1("t6_async_valid", rsp_valid, 1'b0);
        chk1("t6_async_ready0", req0_ready, 1'b0);
        req0_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk1("t6_no_rsp", rsp_valid, 1'b0);
        end
        run_op("t6_req1", 1'b1, 2'b11, 16'h1234, 16'h4321, 16'h5115, 1'b0);

        chk16("never_two_readys", both_cnt, 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
